// File: rtl/shift_right_iter.sv
// Multi-cycle right shifter: one power-of-two stage per clock, fixed latency S+1.
// Define SHIFT_RIGHT_ARITH_EN to add the ARITH port and sign-fill (arithmetic) shifts.
module shift_right_iter #(
    parameter int Nbits = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [Nbits-1:0] A,
    input  logic [Nbits-1:0] B,
`ifdef SHIFT_RIGHT_ARITH_EN
    input  logic             ARITH,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [Nbits-1:0] OUT
);

    localparam int S  = $clog2(Nbits);
    localparam int KW = (S > 1) ? $clog2(S) : 1;
    localparam logic [Nbits-1:0] NB_V = Nbits'(Nbits);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [Nbits-1:0] acc_q, acc_d;
    logic [Nbits-1:0] out_q, out_d;
    logic [S-1:0]     b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             f_q, f_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fill_in;

    // Shift right by 2^k, filling the vacated MSBs with f.
    function automatic logic [Nbits-1:0] stage_shift(
        input logic [Nbits-1:0] v,
        input logic [KW-1:0]    k,
        input logic             f
    );
        logic [Nbits-1:0] ones;
        logic [Nbits-1:0] fill_mask;
        int unsigned      amt;
        ones      = '1;
        amt       = 32'd1 << k;
        fill_mask = ~(ones >> amt);
        return (v >> amt) | (f ? fill_mask : '0);
    endfunction

`ifdef SHIFT_RIGHT_ARITH_EN
    assign fill_in = ARITH & A[Nbits-1];
`else
    assign fill_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        b_d     = b_q;
        k_d     = k_q;
        f_d     = f_q;
        busy_d  = (state_q == ST_SHIFT);
        done_d  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    b_d     = B[S-1:0];
                    f_d     = fill_in;
                    // Oversized amounts saturate to all-fill; the stages then leave it unchanged.
                    acc_d   = (B >= NB_V) ? {Nbits{fill_in}} : A;
                    k_d     = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (b_q[k_q]) begin
                    acc_d = stage_shift(acc_q, k_q, f_q);
                end
                if (k_q == KW'(S - 1)) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                out_d   = acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            b_q     <= '0;
            k_q     <= '0;
            f_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            b_q     <= b_d;
            k_q     <= k_d;
            f_q     <= f_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OUT  = out_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// Scoreboard bench for shift_right_iter at Nbits=8; honours SHIFT_RIGHT_ARITH_EN if defined.
module tb_shift_right_iter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       arith;
    logic       busy;
    logic       done;
    logic [7:0] out;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    shift_right_iter #(.Nbits(8)) dut (
        .CLK(clk),
        .RST(rst),
        .START(start),
        .A(a),
        .B(b),
`ifdef SHIFT_RIGHT_ARITH_EN
        .ARITH(arith),
`endif
        .BUSY(busy),
        .DONE(done),
        .OUT(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one-bit-at-a-time right shift, saturating at the operand width.
    function automatic logic [7:0] model(input logic [7:0] av, input logic [7:0] bv, input logic ar);
        logic       f;
        logic [7:0] v;
`ifdef SHIFT_RIGHT_ARITH_EN
        f = ar & av[7];
`else
        f = ar & 1'b0;
`endif
        v = av;
        if (bv >= 8'd8) v = {8{f}};
        else for (int i = 0; i < int'(bv); i++) v = {f, v[7:1]};
        return v;
    endfunction

    task automatic check_done_out(input string name);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected DONE, OUT=%h, scoreboard empty", name, out);
        end else begin
            e = exp_q.pop_front();
            if (out !== e) begin
                bad++;
                $display("FAIL %s: OUT=%h expected=%h", name, out, e);
            end
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ar, input string name);
        int busy_n;
        int done_at;
        @(negedge clk);
        a = av; b = bv; arith = ar; start = 1'b1;
        exp_q.push_back(model(av, bv, ar));
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); arith = 1'($urandom);
        busy_n = 0; done_at = 0;
        for (int c = 1; c <= 10 && done_at == 0; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_at = c;
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_overlap: BUSY=%b with DONE, expected 0", name, busy);
                end
                check_done_out(name);
            end
        end
        total++;
        if (done_at != 4) begin
            bad++;
            $display("FAIL %s_latency: DONE at cycle %0d expected 4", name, done_at);
        end
        total++;
        if (busy_n != 3) begin
            bad++;
            $display("FAIL %s_busy: BUSY cycles=%0d expected 3", name, busy_n);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || out !== model(av, bv, ar)) begin
            bad++;
            $display("FAIL %s_hold: DONE=%b OUT=%h expected 0 and %h", name, done, out, model(av, bv, ar));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; arith = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00) begin
            bad++;
            $display("FAIL reset: BUSY=%b DONE=%b OUT=%h expected 0 0 00", busy, done, out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_op(8'hB4, 8'd2, 1'b0, "logic_b2");
        do_op(8'hB4, 8'd3, 1'b1, "arith_b3");
        do_op(8'h5A, 8'd0, 1'b0, "b_zero");
        do_op(8'h81, 8'd7, 1'b1, "b_max");
    endtask

    task automatic test_overflow();
        do_op(8'hFF, 8'd9, 1'b0, "ovf_logic");
        do_op(8'h80, 8'd200, 1'b1, "ovf_arith");
        do_op(8'hC3, 8'd8, 1'b1, "ovf_edge");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            do_op(8'($urandom), 8'($urandom_range(0, 11)), 1'($urandom), "random");
    endtask

    task automatic test_start_ignored();
        int ndone;
        @(negedge clk);
        a = 8'hB4; b = 8'd2; arith = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'hB4, 8'd2, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h0F; b = 8'd1; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check_done_out("ignore_out");
            end
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL ignore_count: DONE pulses=%0d expected 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        @(negedge clk);
        a = 8'hB4; b = 8'd2; arith = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'hB4, 8'd2, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00) begin
            bad++;
            $display("FAIL midreset: BUSY=%b DONE=%b OUT=%h expected 0 0 00", busy, done, out);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL midreset_done: DONE pulses=%0d expected 0", ndone);
        end
        do_op(8'hB4, 8'd2, 1'b0, "after_reset");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_start_ignored();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_right_iter.md
# shift_right_iter

Multi-cycle right shifter, the right-direction counterpart to the ALU's combinational left-shift unit. Operands are latched on a start pulse and processed one power-of-two stage per clock, with a fixed, data-independent latency and a one-cycle done pulse. It lets the ALU offer right shifts without a full-width combinational barrel path when timing is tight.

## Interface

- Nbits, 4, operand/result width (≥2)
- CLK  input  1  clock, rising-edge
- RST  input  1  reset, asynchronous, active-high
- START  input  1  request; sampled only in IDLE
- A  input  Nbits  value to shift
- B  input  Nbits  shift amount, unsigned
- ARITH  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); present only with SHIFT_RIGHT_ARITH_EN
- BUSY  output  1  high while stages are executing
- DONE  output  1  one-cycle pulse, OUT valid
- OUT  output  Nbits  result, held until the next completion

## Operation

- S = $clog2(Nbits) stages; stage k shifts right by 2^k when B[k]=1.
- Fill bit F = ARITH ? A[Nbits-1] : 0, latched at START.
- FSM states:
  - IDLE: START=1 latches A, B[S-1:0], and F, then moves to SHIFT with stage counter k=0.
  - SHIFT: each cycle, if Bk then acc = {F repeated 2^k, acc[Nbits-1:2^k]}; k++. After stage S-1, moves to DONE.
  - DONE: OUT <= acc; DONE=1 for this one cycle; returns to IDLE.
- Overflow: if B ≥ Nbits at load, acc is loaded with Nbits copies of F. SHIFT still runs all S cycles, so latency is unchanged and the value stays all-F.
- B=0: OUT=A after the full latency.
- START in SHIFT or DONE: ignored, not queued. A, B and ARITH may change freely after the START cycle.
- OUT updates only in DONE and holds otherwise.

## Timing

- Reset values: state IDLE; OUT=0, BUSY=0, DONE=0, internal acc and k = 0.
- START sampled high at edge 0:
  - BUSY high after edges 1..S.
  - DONE high and OUT valid after edge S+1.
  - Earliest next START is accepted at edge S+2.
- Latency = S+1 cycles. Throughput = one operation per S+2 cycles.
- RST asserted mid-operation: immediate return to reset values. No DONE is produced and the operation is discarded.
- BUSY and DONE are never high together.

## Configuration

- SHIFT_RIGHT_ARITH_EN defined:
  - ARITH port exists.
  - Arithmetic shift supported; F taken from A's MSB when ARITH=1.
- SHIFT_RIGHT_ARITH_EN undefined:
  - ARITH port absent.
  - F fixed at 0 (logical shift only).
  - Overflow result is always 0.

## Test plan

- Nbits=8, A=8'hB4, B=2, ARITH=0, one-cycle START -> BUSY high 3 cycles, DONE pulse 4 cycles after START, OUT=8'h2D.
- Nbits=8, A=8'hB4, B=3, ARITH=1 (macro defined) -> OUT=8'hF6. Same stimulus without macro -> OUT=8'h16.
- Nbits=8, overflow shift amounts:
  - A=8'hFF, B=9, ARITH=0 -> OUT=8'h00.
  - A=8'h80, B=200, ARITH=1 -> OUT=8'hFF.
  - Both at the standard 4-cycle latency.
- Nbits=8, A=8'h5A, B=0 -> OUT=8'h5A after 4 cycles.
- START pulsed while BUSY with different operands -> ignored. First result is delivered unchanged and no second DONE occurs.
- Start A=8'hB4, B=2, then assert RST after 2 cycles -> no DONE; OUT=0, BUSY=0. A new START after RST release completes normally.
